// File: rtl/bch_dec_err_corr.sv
// bch_dec_err_corr: DEC BCH(31,21) error locator/corrector (S1/S3, key equation, serial Chien search)
// Ports: clk_i/rst_i (async active-high reset); cw_i/synd_i/in_valid_i/in_ready_o accept one codeword
// and its 10-bit remainder; data_o/err_cnt_o/uncorr_o/out_valid_o/out_ready_i return the corrected result.
module bch_dec_err_corr #(
    parameter int P_D_WIDTH = 21
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [30:0]          cw_i,
    input  logic [9:0]           synd_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [P_D_WIDTH-1:0] data_o,
    output logic [1:0]           err_cnt_o,
    output logic                 uncorr_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i
);
    localparam int LP_DB_DIFF = 31 - (P_D_WIDTH + 10);
    typedef enum logic [2:0] {IDLE, SYND, KEY, CHIEN, DONE} state_t;
    // Multiplicative inverse in GF(2^5) indexed by field element value (entry 0 unused).
    localparam logic [4:0] INV [32] = '{
        5'd0,  5'd1,  5'd18, 5'd28, 5'd9,  5'd23, 5'd14, 5'd12,
        5'd22, 5'd4,  5'd25, 5'd16, 5'd7,  5'd15, 5'd6,  5'd13,
        5'd11, 5'd24, 5'd2,  5'd29, 5'd30, 5'd26, 5'd8,  5'd5,
        5'd17, 5'd10, 5'd21, 5'd31, 5'd3,  5'd19, 5'd20, 5'd27
    };

    // Multiply by alpha modulo x^5+x^2+1.
    function automatic logic [4:0] mulx(input logic [4:0] a);
        return {a[3], a[2], a[1] ^ a[4], a[0], a[4]};
    endfunction

    function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
        logic [4:0] p;
        p = '0;
        for (int i = 4; i >= 0; i--) p = mulx(p) ^ (b[i] ? a : 5'd0);
        return p;
    endfunction

    // r(alpha) or r(alpha^3); the loop unrolls into constant multipliers.
    function automatic logic [4:0] r_eval(input logic [9:0] r, input logic cube);
        logic [4:0] p, s;
        p = 5'd1;
        s = '0;
        for (int i = 0; i < 10; i++) begin
            s = s ^ (r[i] ? p : 5'd0);
            p = cube ? mulx(mulx(mulx(p))) : mulx(p);
        end
        return s;
    endfunction

    state_t              state_q, state_d;
    logic [30:0]         cw_q, cw_d;
    logic [P_D_WIDTH-1:0] orig_q, orig_d;
    logic [9:0]          r_q, r_d;
    logic [4:0]          s1_q, s1_d, s3_q, s3_d, sig1_q, sig1_d, sig2_q, sig2_d, a_q, a_d, j_q, j_d;
    logic [1:0]          roots_q, roots_d, deg_q, deg_d, cnt_q, cnt_d;
    logic                pad_q, pad_d, unc_q, unc_d;
    logic [4:0]          s1_c, s3_c, sig2_c, lam;
    logic                hit, pad_nx, unc_fin;
    logic [1:0]          roots_inc;

    assign in_ready_o  = (state_q == IDLE) & ~rst_i;
    assign out_valid_o = state_q == DONE;
    assign data_o      = cw_q[30 -: P_D_WIDTH];
    assign err_cnt_o   = cnt_q;
    assign uncorr_o    = unc_q;

    always_comb begin
        s1_c      = r_eval(r_q, 1'b0);
        s3_c      = r_eval(r_q, 1'b1);
        sig2_c    = gf_mul(s3_q, INV[s1_q]) ^ gf_mul(s1_q, s1_q);
        lam       = gf_mul(a_q, a_q) ^ gf_mul(sig1_q, a_q) ^ sig2_q;
        hit       = lam == 5'd0;
        roots_inc = (roots_q == 2'd3) ? 2'd3 : roots_q + {1'b0, hit};
        // A root below the pad boundary means the pattern hit bits that were transmitted as zero.
        pad_nx    = pad_q | (hit & (int'(j_q) < LP_DB_DIFF));
        unc_fin   = (roots_inc != deg_q) | pad_nx;
        state_d = state_q;
        cw_d    = cw_q;
        orig_d  = orig_q;
        r_d     = r_q;
        s1_d    = s1_q;
        s3_d    = s3_q;
        sig1_d  = sig1_q;
        sig2_d  = sig2_q;
        a_d     = a_q;
        j_d     = j_q;
        roots_d = roots_q;
        deg_d   = deg_q;
        pad_d   = pad_q;
        cnt_d   = cnt_q;
        unc_d   = unc_q;
        case (state_q)
            IDLE: if (in_valid_i) begin
                state_d = SYND;
                cw_d    = cw_i;
                orig_d  = cw_i[30 -: P_D_WIDTH];
                r_d     = synd_i;
            end
            SYND: begin
                s1_d    = s1_c;
                s3_d    = s3_c;
                state_d = (s1_c == 5'd0) ? DONE : KEY;
                cnt_d   = 2'd0;
                unc_d   = (s1_c == 5'd0) & (s3_c != 5'd0);
            end
            KEY: begin
                sig1_d  = s1_q;
                sig2_d  = sig2_c;
                deg_d   = (sig2_c == 5'd0) ? 2'd1 : 2'd2;
                roots_d = 2'd0;
                pad_d   = 1'b0;
                a_d     = 5'd1;
                j_d     = 5'd0;
                state_d = CHIEN;
            end
            CHIEN: begin
                cw_d[j_q] = cw_q[j_q] ^ hit;
                roots_d   = roots_inc;
                pad_d     = pad_nx;
                a_d       = mulx(a_q);
                j_d       = (j_q == 5'd30) ? j_q : j_q + 5'd1;
                if (j_q == 5'd30) begin
                    state_d = DONE;
                    unc_d   = unc_fin;
                    cnt_d   = unc_fin ? 2'd0 : roots_inc;
                    if (unc_fin) cw_d[30 -: P_D_WIDTH] = orig_q;
                end
            end
            DONE: state_d = out_ready_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cw_q    <= '0;
            orig_q  <= '0;
            r_q     <= '0;
            s1_q    <= '0;
            s3_q    <= '0;
            sig1_q  <= '0;
            sig2_q  <= '0;
            a_q     <= '0;
            j_q     <= '0;
            roots_q <= '0;
            deg_q   <= '0;
            pad_q   <= 1'b0;
            cnt_q   <= '0;
            unc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cw_q    <= cw_d;
            orig_q  <= orig_d;
            r_q     <= r_d;
            s1_q    <= s1_d;
            s3_q    <= s3_d;
            sig1_q  <= sig1_d;
            sig2_q  <= sig2_d;
            a_q     <= a_d;
            j_q     <= j_d;
            roots_q <= roots_d;
            deg_q   <= deg_d;
            pad_q   <= pad_d;
            cnt_q   <= cnt_d;
            unc_q   <= unc_d;
        end
    end
endmodule

// File: tb/tb_bch_dec_err_corr.sv
// tb_bch_dec_err_corr: directed bench for full-length (21) and shortened (16) decoders sharing one stimulus
module tb_bch_dec_err_corr;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [30:0] cw_i = '0;
    logic [9:0]  synd_i = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        ir21, ov21, u21, ir16, ov16, u16;
    logic [20:0] d21;
    logic [15:0] d16;
    logic [1:0]  c21, c16;
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    bch_dec_err_corr #(.P_D_WIDTH(21)) dut21 (
        .clk_i(clk), .rst_i(rst), .cw_i(cw_i), .synd_i(synd_i), .in_valid_i(in_valid),
        .in_ready_o(ir21), .data_o(d21), .err_cnt_o(c21), .uncorr_o(u21),
        .out_valid_o(ov21), .out_ready_i(out_ready)
    );

    bch_dec_err_corr #(.P_D_WIDTH(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .cw_i(cw_i), .synd_i(synd_i), .in_valid_i(in_valid),
        .in_ready_o(ir16), .data_o(d16), .err_cnt_o(c16), .uncorr_o(u16),
        .out_valid_o(ov16), .out_ready_i(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input logic [30:0] cw, input logic [9:0] sy, input int exp_lat,
                       input logic [20:0] ed21, input logic [1:0] ec21, input logic eu21,
                       input logic [15:0] ed16, input logic [1:0] ec16, input logic eu16, input int hold);
        int lat = 0;
        int bad = 0;
        @(negedge clk);
        chk({tag, " ready"}, 32'(ir21 & ir16), 32'd1);
        cw_i = cw;
        synd_i = sy;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cw_i = ~cw;
        synd_i = ~sy;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ov21 && lat < 100);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        @(negedge clk);
        chk({tag, " valid16"}, 32'(ov16), 32'd1);
        chk({tag, " data21"}, 32'(d21), 32'(ed21));
        chk({tag, " cnt21"}, 32'(c21), 32'(ec21));
        chk({tag, " unc21"}, 32'(u21), 32'(eu21));
        chk({tag, " data16"}, 32'(d16), 32'(ed16));
        chk({tag, " cnt16"}, 32'(c16), 32'(ec16));
        chk({tag, " unc16"}, 32'(u16), 32'(eu16));
        if (hold > 0) begin
            in_valid = 1'b1;
            cw_i = 31'h5A5A_A5A5;
            synd_i = 10'h2B7;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                bad += (ov21 !== 1'b1 || ir21 !== 1'b0 || d21 !== ed21 || c21 !== ec21 || u21 !== eu21) ? 1 : 0;
            end
            chk({tag, " hold"}, 32'(bad), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk({tag, " release ready"}, 32'(ir21), 32'd1);
        chk({tag, " release valid"}, 32'(ov21 | ov16), 32'd0);
    endtask

    initial begin
        int seen = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", 32'(ir21), 32'd0);
        chk("reset valid", 32'(ov21), 32'd0);
        chk("reset outs", {9'd0, d21, c21}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run("clean",   31'h7FFF_FC00, 10'h000, 1,  21'h1FFFFF, 2'd0, 1'b0, 16'hFFFF, 2'd0, 1'b0, 10);
        run("single10", 31'h0000_0400, 10'h369, 33, 21'h0, 2'd1, 1'b0, 16'h0, 2'd1, 1'b0, 0);
        run("single0", 31'h0000_0001, 10'h001, 33, 21'h0, 2'd1, 1'b0, 16'h0, 2'd0, 1'b1, 0);
        run("double",  31'h0000_0401, 10'h368, 33, 21'h0, 2'd2, 1'b0, 16'h0, 2'd0, 1'b1, 0);
        run("double01", 31'h0000_0003, 10'h003, 33, 21'h0, 2'd2, 1'b0, 16'h0, 2'd0, 1'b1, 0);
        run("uncorr",  31'h0000_0025, 10'h025, 1,  21'h0, 2'd0, 1'b1, 16'h0, 2'd0, 1'b1, 0);
        run("restore", 31'h0000_8001, 10'h17C, 33, 21'h0, 2'd2, 1'b0, 16'h0001, 2'd0, 1'b1, 0);
        run("dataflip", 31'h7FFF_7C00, 10'h17D, 33, 21'h1FFFFF, 2'd1, 1'b0, 16'hFFFF, 2'd1, 1'b0, 0);
        @(negedge clk);
        cw_i = 31'h0000_0401;
        synd_i = 10'h368;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst valid", 32'(ov21), 32'd0);
        chk("midrst ready", 32'(ir21), 32'd0);
        chk("midrst outs", {9'd0, d21, c21}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst ready", 32'(ir21), 32'd1);
        repeat (40) begin
            @(negedge clk);
            seen += ov21 ? 1 : 0;
        end
        chk("postrst no valid", 32'(seen), 32'd0);
        run("after", 31'h0000_0401, 10'h368, 33, 21'h0, 2'd2, 1'b0, 16'h0, 2'd0, 1'b1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
